dcache_bank_arbiter: RTL

- Schedules the single-ported data array of one dcache bank among three requesters: the load pipeline (word read), the store/write-buffer drain (masked word write) and the L2 fill return (full 32B block write).
- Owns a 256b fill buffer and sequences each fill as 8 consecutive word writes.
- Uses a starvation counter so stores cannot be locked out by loads.
- The dcache instantiates two copies, one per bank, selected by the bank bit.

---
 rtl/dcache_bank_arbiter_pkg.sv | 37 +++
 rtl/dcache_bank_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_bank_arbiter_pkg.sv
// Shared dcache definitions used by the bank arbiter: data-array geometry,
// fill sequencing constants, arbiter state and grant encodings.
package dcache_bank_arbiter_pkg;

  // Data-array geometry (existing system definitions)
  localparam int DCACHE_DATA_WORD_INDEX_WIDTH = 9;
  localparam int DCACHE_INDEX_WIDTH           = 6;
  localparam int DCACHE_DATA_WORD_WIDTH       = 32;
  localparam int DCACHE_BLOCK_SIZE            = 256;  // block size in bits (32 bytes)

  // A fill is written as one data word per cycle
  localparam int DCACHE_FILL_BEATS = DCACHE_BLOCK_SIZE / DCACHE_DATA_WORD_WIDTH;
  localparam int DCACHE_BEAT_WIDTH = $clog2(DCACHE_FILL_BEATS);

  // Arbiter sequencing state
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } dcache_arb_state_t;

  // Which requester owns the array in the current IDLE cycle
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_LOAD  = 2'd1,
    GNT_STORE = 2'd2,
    GNT_FILL  = 2'd3
  } dcache_arb_grant_t;

  // Data-array row of one beat of a block: set index on top, word offset below
  function automatic logic [DCACHE_DATA_WORD_INDEX_WIDTH-1:0] fill_row(
    input logic [DCACHE_INDEX_WIDTH-1:0] set_index,
    input logic [DCACHE_BEAT_WIDTH-1:0]  beat
  );
    return {set_index, beat};
  endfunction

endpackage

// File: rtl/dcache_bank_arbiter.sv
// Data-array scheduler for one dcache bank. Arbitrates between load reads,
// masked store writes and 8-beat L2 fills, with a starvation counter that
// lifts a waiting store above everything else after STORE_STARVE_MAX denials.
module dcache_bank_arbiter
  import dcache_bank_arbiter_pkg::*;
#(
  parameter int STORE_STARVE_MAX = 4
) (
  input  logic         CLK,
  input  logic         RST,
  // load pipeline
  input  logic         load_valid,
  input  logic [8:0]   load_word_index,
  output logic         load_ready,
  output logic         load_resp_valid,
  // store / write-buffer drain
  input  logic         store_valid,
  input  logic         store_way,
  input  logic [8:0]   store_word_index,
  input  logic [31:0]  store_wdata,
  input  logic [3:0]   store_byte_mask,
  output logic         store_ready,
  // L2 fill return
  input  logic         fill_valid,
  input  logic         fill_way,
  input  logic [5:0]   fill_index,
  input  logic [255:0] fill_data,
  output logic         fill_ready,
  output logic         fill_done,
  // data array
  output logic         array_en,
  output logic         array_we,
  output logic         array_way,
  output logic [8:0]   array_row,
  output logic [31:0]  array_wdata,
  output logic [3:0]   array_wmask,
  output logic         busy
);

  localparam logic [3:0]                   STARVE_MAX = 4'(STORE_STARVE_MAX);
  localparam logic [DCACHE_BEAT_WIDTH-1:0] LAST_BEAT  = DCACHE_BEAT_WIDTH'(DCACHE_FILL_BEATS - 1);

  dcache_arb_state_t              state_reg, state_next;
  logic [DCACHE_BEAT_WIDTH-1:0]   beat_reg, beat_next;
  logic [3:0]                     starve_cnt_reg, starve_cnt_next;
  logic                           load_resp_valid_reg;
  // Set for the single IDLE cycle following a fill so a second fill cannot
  // take the array back-to-back and pending loads/stores get a slot.
  logic                           fill_hold_reg, fill_hold_next;
  logic [DCACHE_BLOCK_SIZE-1:0]   fill_buf_reg;
  logic                           fill_way_reg;
  logic [DCACHE_INDEX_WIDTH-1:0]  fill_index_reg;

  dcache_arb_grant_t              grant;
  logic                           store_starved;
  logic                           in_fill;

  assign in_fill = !RST && (state_reg == FILL);

  // Priority select in IDLE: starved store > fill > load > store
  always_comb begin
    grant         = GNT_NONE;
    store_starved = store_valid && (starve_cnt_reg == STARVE_MAX);
    if (!RST && (state_reg == IDLE)) begin
      if (store_starved) begin
        grant = GNT_STORE;
      end else if (fill_valid && !fill_hold_reg) begin
        grant = GNT_FILL;
      end else if (load_valid) begin
        grant = GNT_LOAD;
      end else if (store_valid) begin
        grant = GNT_STORE;
      end
    end
  end

  // Array drive, handshakes and next-state sequencing from the grant/state
  always_comb begin
    load_ready      = 1'b0;
    store_ready     = 1'b0;
    fill_ready      = 1'b0;
    fill_done       = 1'b0;
    array_en        = 1'b0;
    array_we        = 1'b0;
    array_way       = 1'b0;
    array_row       = '0;
    array_wdata     = '0;
    array_wmask     = '0;
    busy            = in_fill;
    state_next      = state_reg;
    beat_next       = beat_reg;
    fill_hold_next  = 1'b0;
    starve_cnt_next = starve_cnt_reg;

    case (grant)
      GNT_LOAD: begin
        load_ready = 1'b1;
        array_en   = 1'b1;
        array_row  = load_word_index;
      end
      GNT_STORE: begin
        store_ready = 1'b1;
        array_en    = 1'b1;
        array_we    = 1'b1;
        array_way   = store_way;
        array_row   = store_word_index;
        array_wdata = store_wdata;
        array_wmask = store_byte_mask;
      end
      GNT_FILL: begin
        // Beat 0 goes straight from the live inputs; the rest from the buffer
        fill_ready  = 1'b1;
        array_en    = 1'b1;
        array_we    = 1'b1;
        array_way   = fill_way;
        array_row   = fill_row(fill_index, '0);
        array_wdata = fill_data[DCACHE_DATA_WORD_WIDTH-1:0];
        array_wmask = 4'hF;
        state_next  = FILL;
        beat_next   = DCACHE_BEAT_WIDTH'(1);
      end
      default: ;
    endcase

    if (in_fill) begin
      array_en    = 1'b1;
      array_we    = 1'b1;
      array_way   = fill_way_reg;
      array_row   = fill_row(fill_index_reg, beat_reg);
      array_wdata = fill_buf_reg[{beat_reg, 5'd0} +: DCACHE_DATA_WORD_WIDTH];
      array_wmask = 4'hF;
      if (beat_reg == LAST_BEAT) begin
        fill_done      = 1'b1;
        state_next     = IDLE;
        beat_next      = '0;
        fill_hold_next = 1'b1;
      end else begin
        beat_next = beat_reg + DCACHE_BEAT_WIDTH'(1);
      end
    end

    // A denied store ages (also while a fill owns the array); a grant resets it
    if (store_ready) begin
      starve_cnt_next = '0;
    end else if (store_valid && (starve_cnt_reg != STARVE_MAX)) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  assign load_resp_valid = load_resp_valid_reg;

  // Sequencing state, starvation age and the one-cycle load response flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg           <= IDLE;
      beat_reg            <= '0;
      starve_cnt_reg      <= '0;
      fill_hold_reg       <= 1'b0;
      load_resp_valid_reg <= 1'b0;
    end else begin
      state_reg           <= state_next;
      beat_reg            <= beat_next;
      starve_cnt_reg      <= starve_cnt_next;
      fill_hold_reg       <= fill_hold_next;
      load_resp_valid_reg <= load_ready;
    end
  end

  // Fill buffer: capture the whole block plus target on acceptance
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fill_buf_reg   <= '0;
      fill_way_reg   <= 1'b0;
      fill_index_reg <= '0;
    end else if (fill_ready) begin
      fill_buf_reg   <= fill_data;
      fill_way_reg   <= fill_way;
      fill_index_reg <= fill_index;
    end
  end

endmodule
